fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Write-domain scheduler that shares the single write port of the async FIFO between NUM_REQ requesters.
- Round-robin arbitration with bounded bursts: a granted requester keeps the port for up to MAX_BURST beats, then priority rotates.
- Sits on the FIFO's clk_wr side. Drives the FIFO write-enable and data, and honours w_full.
- Counts stall cycles for debug.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- data_size, 8, width of one data beat; matches the FIFO data width.
- MAX_BURST, 4, maximum beats per grant (1..16).
- CNT_W, 16, width of the stall counter.

Ports:
- clk_wr  input  1  write-domain clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk_wr.
- en  input  1  arbitration enable; when low, no new grant is issued.
- req  input  NUM_REQ  per-requester beat-valid; held until acked.
- data  input  NUM_REQ*data_size  requester k's data in slice [k*data_size +: data_size].
- ack  output  NUM_REQ  one-hot; high in the cycle requester k's beat is written.
- w_full  input  1  FIFO full flag, already in the clk_wr domain.
- fifo_we  output  1  FIFO write strobe.
- fifo_wdata  output  data_size  FIFO write data.
- busy  output  1  high while in BURST.
- owner  output  clog2(NUM_REQ)  current or last granted requester index.
- stall_cnt  output  CNT_W  saturating count of cycles stalled by w_full.

Behaviour:
- States: IDLE, BURST. Registered: state, owner, beat_cnt (clog2(MAX_BURST)+1 bits), stall_cnt.
- Reset (reset==0 at a clock edge):
  - state=IDLE, owner=NUM_REQ-1 (so req[0] has first priority), beat_cnt=0, stall_cnt=0.
  - Combinationally this gives ack=0, fifo_we=0, busy=0.
  - Reset mid-burst aborts the burst immediately; no further beats are written.
- IDLE:
  - If en=1 and req!=0, pick the first set bit scanning owner+1, owner+2, ... modulo NUM_REQ.
  - Load owner with that index, set beat_cnt=0, go to BURST.
  - No write occurs in IDLE, so arbitration costs 1 cycle.
- BURST, accept condition: accept = req[owner] & ~w_full.
  - fifo_we = accept; fifo_wdata = data slice of owner; ack[owner] = accept. All combinational, same cycle.
  - fifo_wdata equals the owner's slice whenever busy=1. It is 0 in IDLE.
- BURST, accept=1: beat_cnt increments. If beat_cnt==MAX_BURST-1, go to IDLE (burst complete).
- BURST, req[owner]=0: go to IDLE with no write; owner is retained for the rotation.
- BURST, req[owner]=1 and w_full=1: hold state, no write. stall_cnt increments, saturating at all-ones.
- en only gates leaving IDLE. An active burst runs to completion regardless of en.
- Fairness:
  - Back-to-back bursts from different requesters are separated by exactly one IDLE cycle.
  - Maximum wait for a continuously requesting port is (NUM_REQ-1)*(MAX_BURST+1) cycles, plus full stalls.
- ack is never set for a non-owner. At most one ack bit is high per cycle.
- Requesters may change data only after ack. Dropping req before ack is legal and ends that grant.
- owner changes only on the IDLE->BURST transition.

Decomposition:
- Shared package fifo_pkg holds:
  - default data_size and addr_size, shared with the FIFO;
  - the state enum {IDLE, BURST};
  - a helper function clog2.
- One natural sub-module: rr_pick. This is a combinational rotate-priority encoder taking req and the last owner, returning a valid flag and the next index. It is reusable for a future read-side scheduler.

Test Plan:
- Reset/priority: reset held low 2 cycles, then released with req=4'b1111 and w_full=0.
  - Required: cycle 1 IDLE; owner=0.
  - Then ack[0] high for 4 consecutive cycles with data 0x00,0x04,0x08,0x0C on fifo_wdata.
  - Then 1 IDLE cycle, then owner=1.
- Rotation: req=4'b1010 held continuously, MAX_BURST=4.
  - Required grant order 1,3,1,3.
  - Each grant is 4 writes; fifo_we pattern is 0,1,1,1,1 repeating.
- Full stall: owner=2 mid-burst after 2 beats; w_full=1 for 5 cycles, then 0.
  - Required: fifo_we=0 and ack=0 for 5 cycles; stall_cnt increases by 5.
  - Then the remaining 2 beats are written; no beat is lost or duplicated.
- Early drop: req[0] deasserted after 1 accepted beat while req[2]=1.
  - Required: next cycle IDLE, following cycle owner=2.
  - Exactly 1 write is attributed to requester 0.
- Enable gating: en=0 with req=4'b0001.
  - Required: busy stays 0 and fifo_we stays 0.
  - After en=1: grant within 1 cycle.
  - Also: deasserting en mid-burst still completes all 4 beats.
- Mid-burst reset: reset driven low during beat 2 of a burst.
  - Required: next cycle fifo_we=0, ack=0, state=IDLE, stall_cnt=0.
  - After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Definitions shared by the async FIFO and its write-side scheduler.
// Holds default widths, the arbiter state encoding and a clog2 helper.
package fifo_pkg;

  localparam int DEFAULT_DATA_SIZE = 8;
  localparam int DEFAULT_ADDR_SIZE = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Ceiling log2; usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first set request
// after 'last', wrapping modulo NUM_REQ.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to last+1 so the nearest set bit wins.
  always_comb begin
    valid = |req;
    idx   = last;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler for the async FIFO with bounded bursts,
// full-flag back-pressure and a saturating stall counter.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int data_size = DEFAULT_DATA_SIZE,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                           clk_wr,
  input  logic                           reset,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*data_size-1:0]   data,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           w_full,
  output logic                           fifo_we,
  output logic [data_size-1:0]           fifo_wdata,
  output logic                           busy,
  output logic [clog2(NUM_REQ)-1:0]      owner,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int OW = clog2(NUM_REQ);
  localparam int BW = clog2(MAX_BURST) + 1;

  arb_state_t        state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              pick_valid;
  logic [OW-1:0]     pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_rr_pick (
    .req   (req),
    .last  (owner_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_wr) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OW'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // Dropping req ends the grant; owner is kept so rotation continues past it.
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (w_full) begin
          if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == BURST);
    fifo_we    = 1'b0;
    fifo_wdata = '0;
    ack        = '0;
    if (state_q == BURST) begin
      fifo_wdata   = data[owner_q*data_size +: data_size];
      fifo_we      = req[owner_q] & ~w_full;
      ack[owner_q] = req[owner_q] & ~w_full;
    end
  end

  assign owner     = owner_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset priority, rotation, full stall,
// early drop, enable gating and mid-burst reset.
module tb_fifo_wr_arbiter;

  logic        clk_wr;
  logic        reset;
  logic        en;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        w_full;
  logic        fifo_we;
  logic [7:0]  fifo_wdata;
  logic        busy;
  logic [1:0]  owner;
  logic [15:0] stall_cnt;

  int checks;
  int errors;
  int beat   [4];
  int wr_cnt [4];

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .data_size (8),
    .MAX_BURST (4),
    .CNT_W     (16)
  ) dut (
    .clk_wr     (clk_wr),
    .reset      (reset),
    .en         (en),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .w_full     (w_full),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .busy       (busy),
    .owner      (owner),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    clk_wr = 1'b0;
    forever #5 clk_wr = ~clk_wr;
  end

  // Requester k presents beat_k*4 + k and advances only after its ack.
  always_comb begin
    data = '0;
    for (int k = 0; k < 4; k++) begin
      data[k*8 +: 8] = 8'(beat[k] * 4 + k);
    end
  end

  always @(posedge clk_wr) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        beat[k]   <= 0;
        wr_cnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ack[k] && fifo_we) begin
          beat[k]   <= beat[k] + 1;
          wr_cnt[k] <= wr_cnt[k] + 1;
          $display("write: req=%0d data=%02h t=%0t", k, fifo_wdata, $time);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_wr);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b0;
    req    = 4'b0000;
    w_full = 1'b0;
    en     = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    en     = 1'b1;
    w_full = 1'b0;
    req    = 4'b0000;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", fifo_we); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %04b want 0000", ack); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner: got %0d want 3", owner); end
    reset = 1'b1;
    req   = 4'b1111;
    #1;
    checks++; if (busy !== 1'b0 || fifo_we !== 1'b0) begin errors++; $display("FAIL first_idle: busy=%0b we=%0b want 0 0", busy, fifo_we); end
    tick();
    checks++; if (owner !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL first_grant: owner=%0d busy=%0b want 0 1", owner, busy); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (ack !== 4'b0001 || fifo_we !== 1'b1) begin errors++; $display("FAIL prio_beat%0d: ack=%04b we=%0b want 0001 1", b, ack, fifo_we); end
      checks++; if (fifo_wdata !== 8'(b * 4)) begin errors++; $display("FAIL prio_data%0d: got %02h want %02h", b, fifo_wdata, 8'(b * 4)); end
      tick();
    end
    checks++; if (busy !== 1'b0 || fifo_we !== 1'b0) begin errors++; $display("FAIL prio_gap: busy=%0b we=%0b want 0 0", busy, fifo_we); end
    tick();
    checks++; if (owner !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL prio_next: owner=%0d busy=%0b want 1 1", owner, busy); end
    req = 4'b0000;
    #1;
    tick();
  endtask

  task automatic test_rotation;
    int order [4];
    order = '{1, 3, 1, 3};
    do_reset();
    req = 4'b1010;
    #1;
    for (int g = 0; g < 4; g++) begin
      checks++; if (busy !== 1'b0 || fifo_we !== 1'b0) begin errors++; $display("FAIL rot_idle%0d: busy=%0b we=%0b want 0 0", g, busy, fifo_we); end
      tick();
      checks++; if (owner !== 2'(order[g])) begin errors++; $display("FAIL rot_owner%0d: got %0d want %0d", g, owner, order[g]); end
      for (int b = 0; b < 4; b++) begin
        checks++; if (fifo_we !== 1'b1 || ack !== 4'(1 << order[g])) begin errors++; $display("FAIL rot_beat%0d_%0d: we=%0b ack=%04b want 1 %04b", g, b, fifo_we, ack, 4'(1 << order[g])); end
        tick();
      end
    end
    req = 4'b0000;
    #1;
    tick();
  endtask

  task automatic test_full_stall;
    do_reset();
    req = 4'b0100;
    #1;
    tick();
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL stall_owner: got %0d want 2", owner); end
    for (int b = 0; b < 2; b++) begin
      checks++; if (ack !== 4'b0100 || fifo_wdata !== 8'(b * 4 + 2)) begin errors++; $display("FAIL stall_pre%0d: ack=%04b data=%02h want 0100 %02h", b, ack, fifo_wdata, 8'(b * 4 + 2)); end
      tick();
    end
    w_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (fifo_we !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: we=%0b ack=%04b busy=%0b want 0 0000 1", i, fifo_we, ack, busy); end
      tick();
    end
    w_full = 1'b0;
    #1;
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
    for (int b = 2; b < 4; b++) begin
      checks++; if (fifo_we !== 1'b1 || fifo_wdata !== 8'(b * 4 + 2)) begin errors++; $display("FAIL stall_post%0d: we=%0b data=%02h want 1 %02h", b, fifo_we, fifo_wdata, 8'(b * 4 + 2)); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end: busy=%0b want 0", busy); end
    checks++; if (wr_cnt[2] !== 4) begin errors++; $display("FAIL stall_writes: got %0d want 4", wr_cnt[2]); end
    req = 4'b0000;
    #1;
  endtask

  task automatic test_early_drop;
    do_reset();
    req = 4'b0101;
    #1;
    tick();
    checks++; if (owner !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL drop_first: owner=%0d ack=%04b want 0 0001", owner, ack); end
    tick();
    req = 4'b0100;
    #1;
    checks++; if (fifo_we !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL drop_nowrite: we=%0b ack=%04b want 0 0000", fifo_we, ack); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: busy=%0b want 0", busy); end
    tick();
    checks++; if (owner !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL drop_next: owner=%0d busy=%0b want 2 1", owner, busy); end
    checks++; if (wr_cnt[0] !== 1) begin errors++; $display("FAIL drop_count: got %0d want 1", wr_cnt[0]); end
    req = 4'b0000;
    #1;
    tick();
  endtask

  task automatic test_enable;
    do_reset();
    en  = 1'b0;
    req = 4'b0001;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0 || fifo_we !== 1'b0) begin errors++; $display("FAIL en_gate%0d: busy=%0b we=%0b want 0 0", i, busy, fifo_we); end
      tick();
    end
    en = 1'b1;
    #1;
    tick();
    checks++; if (busy !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL en_grant: busy=%0b owner=%0d want 1 0", busy, owner); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (fifo_we !== 1'b1) begin errors++; $display("FAIL en_beat%0d: we=%0b want 1", b, fifo_we); end
      if (b == 0) en = 1'b0;
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_done: busy=%0b want 0", busy); end
    checks++; if (wr_cnt[0] !== 4) begin errors++; $display("FAIL en_count: got %0d want 4", wr_cnt[0]); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_regate: busy=%0b want 0", busy); end
    en  = 1'b1;
    req = 4'b0000;
    #1;
  endtask

  task automatic test_midburst_reset;
    do_reset();
    req = 4'b0010;
    #1;
    tick();
    checks++; if (owner !== 2'd1) begin errors++; $display("FAIL mrst_owner: got %0d want 1", owner); end
    w_full = 1'b1;
    #1;
    tick();
    w_full = 1'b0;
    #1;
    checks++; if (fifo_we !== 1'b1) begin errors++; $display("FAIL mrst_beat1: we=%0b want 1", fifo_we); end
    tick();
    checks++; if (fifo_we !== 1'b1) begin errors++; $display("FAIL mrst_beat2: we=%0b want 1", fifo_we); end
    reset = 1'b0;
    #1;
    tick();
    checks++; if (fifo_we !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL mrst_abort: we=%0b ack=%04b want 0 0000", fifo_we, ack); end
    checks++; if (busy !== 1'b0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL mrst_state: busy=%0b stall=%0d want 0 0", busy, stall_cnt); end
    reset = 1'b1;
    req   = 4'b1111;
    #1;
    tick();
    checks++; if (owner !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL mrst_restart: owner=%0d busy=%0b want 0 1", owner, busy); end
    req = 4'b0000;
    #1;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    en     = 1'b1;
    w_full = 1'b0;
    req    = 4'b0000;
    test_reset();
    test_rotation();
    test_full_stall();
    test_early_drop();
    test_enable();
    test_midburst_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
